// File: rtl/cpu_debounce_pkg.sv
// cpu_debounce_pkg: shared debounce FSM encoding, default debounce length and counter-width helper
package cpu_debounce_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } db_state_e;
  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/cpu_debounce_bit.sv
// cpu_debounce_bit: one switch bit -- clk/reset in, raw_i async level in; stable_o debounced level, rise_o/fall_o one-cycle edge pulses out
module cpu_debounce_bit
  import cpu_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1_q, s2_q;
  logic stable_q, stable_d;
  logic rise_q, rise_d, fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;
  db_state_e state_q, state_d;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (state_q == IDLE) begin
      cnt_d   = s2_q != stable_q ? CW'(1) : '0;
      state_d = s2_q != stable_q ? COUNT : IDLE;
    end else if (s2_q == stable_q) begin
      cnt_d   = '0;
      state_d = IDLE;
    end else if (cnt_q == LAST) begin
      stable_d = s2_q;
      cnt_d    = '0;
      state_d  = IDLE;
      rise_d   = s2_q;
      fall_d   = ~s2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
      state_q  <= IDLE;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end
  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
endmodule

// File: rtl/cpu_switch_debounce.sv
// cpu_switch_debounce: WIDTH-bit switch debouncer -- sw_raw in; sw_stable, sw_rise, sw_fall per bit and sw_changed summary out
module cpu_switch_debounce
  import cpu_debounce_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    cpu_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (sw_raw[i]),
      .stable_o(sw_stable[i]),
      .rise_o  (sw_rise[i]),
      .fall_o  (sw_fall[i])
    );
  end
  assign sw_changed = |{sw_rise, sw_fall};
endmodule

// File: tb/tb_cpu_switch_debounce.sv
// tb_cpu_switch_debounce: directed and randomized checks of the debouncer against a run-length reference model
module tb_cpu_switch_debounce;
  localparam int N = 8;
  localparam int W = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_stable, sw_rise, sw_fall;
  logic sw_changed;
  int passed = 0;
  int total = 0;
  logic [W-1:0] m_stable = '0, m_rise = '0, m_fall = '0;
  int run [W];
  logic [W-1:0] hist[$];
  cpu_switch_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic step();
    logic [W-1:0] smp;
    @(posedge clk);
    if (reset) begin
      hist.delete();
      m_stable = '0;
      m_rise = '0;
      m_fall = '0;
      for (int b = 0; b < W; b++) run[b] = 0;
    end else begin
      smp = hist.size() >= 2 ? hist[hist.size()-2] : '0;
      hist.push_back(sw_raw);
      if (hist.size() > 2) void'(hist.pop_front());
      m_rise = '0;
      m_fall = '0;
      for (int b = 0; b < W; b++) begin
        run[b] = smp[b] != m_stable[b] ? run[b] + 1 : 0;
        if (run[b] == N) begin
          m_stable[b] = smp[b];
          m_rise[b] = smp[b];
          m_fall[b] = ~smp[b];
          run[b] = 0;
        end
      end
    end
    #1;
    chk("stable", 16'(sw_stable), 16'(m_stable));
    chk("rise", 16'(sw_rise), 16'(m_rise));
    chk("fall", 16'(sw_fall), 16'(m_fall));
    chk("changed", 16'(sw_changed), 16'(|{m_rise, m_fall}));
    chk("rise_fall_overlap", 16'(sw_rise & sw_fall), 16'(0));
  endtask
  initial begin
    int first, nr, nc, bad, hold;
    for (int b = 0; b < W; b++) run[b] = 0;
    reset = 1'b1;
    sw_raw = 2'b00;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("reset_outputs", 16'({sw_stable, sw_rise, sw_fall, sw_changed}), 16'(0));
    sw_raw = 2'b01;
    first = 0; nr = 0; nc = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (first == 0 && sw_stable == 2'b01) first = k;
      nr += (sw_rise == 2'b01);
      nc += sw_changed;
    end
    chk("rise_latency", 16'(first), 16'(10));
    chk("rise_pulse_count", 16'(nr), 16'(1));
    chk("rise_changed_count", 16'(nc), 16'(1));
    sw_raw = 2'b00;
    repeat (20) step();
    bad = 0;
    for (int r = 0; r < 4; r++) begin
      sw_raw = 2'b01;
      for (int k = 0; k < 5; k++) begin
        step();
        bad += (sw_stable != 2'b00) + sw_changed;
      end
      sw_raw = 2'b00;
      for (int k = 0; k < 5; k++) begin
        step();
        bad += (sw_stable != 2'b00) + sw_changed;
      end
    end
    chk("glitch_disturbance", 16'(bad), 16'(0));
    sw_raw = 2'b11;
    repeat (20) step();
    chk("both_high", 16'(sw_stable), 16'(2'b11));
    sw_raw = 2'b00;
    first = 0; nr = 0; nc = 0; bad = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (first == 0 && sw_stable == 2'b00) first = k;
      bad += (sw_stable == 2'b01) || (sw_stable == 2'b10);
      nr += (sw_fall == 2'b11);
      nc += sw_changed;
    end
    chk("fall_latency", 16'(first), 16'(10));
    chk("fall_split_bits", 16'(bad), 16'(0));
    chk("fall_pulse_count", 16'(nr), 16'(1));
    chk("fall_changed_count", 16'(nc), 16'(1));
    sw_raw = 2'b10;
    nc = 0;
    repeat (7) begin
      step();
      nc += sw_changed;
    end
    chk("pre_reset_pulses", 16'(nc), 16'(0));
    reset = 1'b1;
    step();
    chk("abort_stable", 16'(sw_stable), 16'(0));
    reset = 1'b0;
    first = 0; nr = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (first == 0 && sw_stable == 2'b10) first = k;
      if (sw_rise == 2'b10) nr = k;
    end
    chk("requalify_latency", 16'(first), 16'(10));
    chk("requalify_rise_edge", 16'(nr), 16'(10));
    hold = 0;
    for (int k = 0; k < 10000; k++) begin
      if (hold == 0) begin
        sw_raw = sw_raw ^ W'($urandom_range(0, 3));
        hold = $urandom_range(1, 14);
      end
      hold--;
      reset = $urandom_range(0, 999) == 0;
      step();
    end
    reset = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
